// File: rtl/tx_frm_sync_pkg.sv
// Shared FSM encoding and header-length helpers for the TX frame synchroniser.
// Pure combinational helpers, no latency, no flow control.
package tx_frm_sync_pkg;

    localparam int ST_W = 5;

    // One-hot state encoding
    localparam logic [ST_W-1:0] ST_INIT = 5'b00001;
    localparam logic [ST_W-1:0] ST_HDR  = 5'b00010;
    localparam logic [ST_W-1:0] ST_CHK  = 5'b00100;
    localparam logic [ST_W-1:0] ST_WAIT = 5'b01000;
    localparam logic [ST_W-1:0] ST_ERR  = 5'b10000;

    function automatic logic [7:0] ben_from_len(input logic [2:0] len_lo);
        if (len_lo == 3'd0) begin
            return 8'hFF;
        end
        return (8'd1 << len_lo) - 8'd1;
    endfunction

    function automatic logic [12:0] qw_ceil(input logic [15:0] len);
        return len[15:3] + {12'd0, |len[2:0]};
    endfunction

endpackage

// File: rtl/tx_ring_occ.sv
// Ring occupancy tracker: registered diff (1 cycle) and rsk (2 cycles from pointers).
// No backpressure; clr forces diff to zero while the synchroniser initialises.
module tx_ring_occ #(
    parameter int BW      = 9,
    parameter int RSK_THR = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [BW:0]   rd_ptr,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   diff,
    output logic          rsk
);

    localparam logic [31:0] THR = RSK_THR;

    // Modular subtraction across the wrap bit gives 0..2^BW directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            rsk  <= 1'b0;
        end else begin
            diff <= clr ? '0 : (committed_prod - rd_ptr);
            rsk  <= (32'(diff) >= THR);
        end
    end

endmodule

// File: rtl/tx_frm_sync_gen.sv
// TX frame synchroniser: parses the header length at rd_ptr and pulses trig once the frame is committed.
// Latency: trig one cycle after CHK; no backpressure, the consumer paces via rsk_tk and sync.
module tx_frm_sync_gen
    import tx_frm_sync_pkg::*;
#(
    parameter int BW      = 9,
    parameter int LEN_LSB = 32,
    parameter int RSK_THR = 16,
    parameter int MAX_LEN = 9018
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW:0]   rd_ptr,
    input  logic [63:0]   rd_data,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   diff,
    output logic          trig,
    output logic [12:0]   qw_len,
    output logic [7:0]    lst_ben,
    output logic          rsk,
    input  logic          rsk_tk,
    input  logic          sync,
    output logic          err,
    output logic [31:0]   frm_cnt
);

    localparam logic [31:0] MAX_LEN_W = MAX_LEN;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [15:0]     len;
    logic [15:0]     hdr_len;
    logic            diff_nz;
    logic            len_bad;
    logic            fits;
    logic            cap_en;
    logic            trig_set;
    logic            err_set;
    logic            unused_data;

    assign hdr_len     = rd_data[LEN_LSB +: 16];
    assign unused_data = ^rd_data;
    assign diff_nz     = |diff;
    assign len_bad     = (len == 16'd0) || ({16'd0, len} > MAX_LEN_W);
    // Header plus qw_len data QWs must all be committed
    assign fits        = (32'(diff) > 32'(qw_len));

    tx_ring_occ #(
        .BW      (BW),
        .RSK_THR (RSK_THR)
    ) u_occ (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (state == ST_INIT),
        .rd_ptr         (rd_ptr),
        .committed_prod (committed_prod),
        .diff           (diff),
        .rsk            (rsk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_HDR;
            ST_HDR:  if (diff_nz) state_nxt = ST_CHK;
            ST_CHK: begin
                if (len_bad) begin
                    state_nxt = ST_ERR;
                end else if (rsk_tk || fits) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_HDR;
                end
            end
            ST_WAIT: begin
                if (sync) begin
                    state_nxt = diff_nz ? ST_CHK : ST_HDR;
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_INIT;
        endcase
    end

    // A speculative start already taken by the consumer suppresses trig
    always_comb begin
        cap_en   = 1'b0;
        trig_set = 1'b0;
        err_set  = 1'b0;
        case (state)
            ST_HDR:  cap_en = diff_nz;
            ST_CHK: begin
                if (len_bad) begin
                    err_set = 1'b1;
                end else if (!rsk_tk && fits) begin
                    trig_set = 1'b1;
                end
            end
            ST_WAIT: cap_en = sync && diff_nz;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig    <= 1'b0;
            err     <= 1'b0;
            frm_cnt <= '0;
            len     <= '0;
            qw_len  <= '0;
            lst_ben <= '0;
        end else begin
            trig <= trig_set;
            if (trig_set) begin
                frm_cnt <= frm_cnt + 32'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if (cap_en) begin
                len     <= hdr_len;
                qw_len  <= qw_ceil(hdr_len);
                lst_ben <= ben_from_len(hdr_len[2:0]);
            end
        end
    end

endmodule

// File: tb/tb_tx_frm_sync_gen.sv
// Randomised and directed bench for tx_frm_sync_gen against a frame-level reference model.
module tb_tx_frm_sync_gen;

    typedef enum {P_INIT, P_HDR, P_CHK, P_WAIT, P_ERR} phase_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_ptr;
    logic [63:0] rd_data;
    logic [9:0]  committed_prod;
    logic [9:0]  diff;
    logic        trig;
    logic [12:0] qw_len;
    logic [7:0]  lst_ben;
    logic        rsk;
    logic        rsk_tk;
    logic        sync;
    logic        err;
    logic [31:0] frm_cnt;

    logic [63:0] ring [512];

    int checks = 0;
    int errors = 0;

    int          m_diff, m_len, m_qw, m_ben;
    logic        m_rsk, m_trig, m_err;
    logic [31:0] m_cnt;
    phase_t      m_ph;

    always #5 clk = ~clk;

    assign rd_data = ring[rd_ptr[8:0]];

    tx_frm_sync_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_ptr         (rd_ptr),
        .rd_data        (rd_data),
        .committed_prod (committed_prod),
        .diff           (diff),
        .trig           (trig),
        .qw_len         (qw_len),
        .lst_ben        (lst_ben),
        .rsk            (rsk),
        .rsk_tk         (rsk_tk),
        .sync           (sync),
        .err            (err),
        .frm_cnt        (frm_cnt)
    );

    task automatic model_reset();
        m_diff = 0; m_len = 0; m_qw = 0; m_ben = 0;
        m_rsk = 1'b0; m_trig = 1'b0; m_err = 1'b0; m_cnt = '0;
        m_ph = P_INIT;
    endtask

    // Frame-level rules: a frame is ready once the QWs after the header hold len bytes
    task automatic model_step();
        int     occ, hl;
        logic   cap;
        logic   n_trig;
        phase_t n_ph;
        occ    = (int'(committed_prod) - int'(rd_ptr)) & 1023;
        hl     = int'(ring[rd_ptr[8:0]][47:32]);
        cap    = 1'b0;
        n_trig = 1'b0;
        n_ph   = m_ph;
        case (m_ph)
            P_INIT: n_ph = P_HDR;
            P_HDR: if (m_diff != 0) begin cap = 1'b1; n_ph = P_CHK; end
            P_CHK: begin
                if (m_len == 0 || m_len > 9018) begin
                    m_err = 1'b1; n_ph = P_ERR;
                end else if (rsk_tk) begin
                    n_ph = P_WAIT;
                end else if ((m_diff - 1) * 8 >= m_len) begin
                    n_trig = 1'b1; m_cnt = m_cnt + 32'd1; n_ph = P_WAIT;
                end else begin
                    n_ph = P_HDR;
                end
            end
            P_WAIT: if (sync) begin
                if (m_diff != 0) begin cap = 1'b1; n_ph = P_CHK; end
                else n_ph = P_HDR;
            end
            default: ;
        endcase
        if (cap) begin
            m_len = hl;
            m_qw  = ((hl + 7) / 8) % 8192;
            m_ben = (hl % 8 == 0) ? 255 : (1 << (hl % 8)) - 1;
        end
        m_rsk  = (m_diff >= 16);
        m_diff = (m_ph == P_INIT) ? 0 : occ;
        m_trig = n_trig;
        m_ph   = n_ph;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_hdr(input int idx, input int len);
        ring[idx][47:32] = 16'(len);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({diff, trig, qw_len, lst_ben, rsk, err, frm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got diff=%0d trig=%0b qw=%0d ben=%h rsk=%0b err=%0b cnt=%0d, want all 0",
                     diff, trig, qw_len, lst_ben, rsk, err, frm_cnt);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (trig !== 1'b0 || frm_cnt !== 32'd0 || diff !== 10'd0) begin
            errors++;
            $display("FAIL reset_release: got trig=%0b cnt=%0d diff=%0d, want 0/0/0", trig, frm_cnt, diff);
        end
    endtask

    task automatic test_exact_fit();
        int ntrig;
        set_hdr(0, 64);
        rd_ptr = 10'd0;
        committed_prod = 10'd8;
        ntrig = 0;
        repeat (8) begin
            tick();
            ntrig += int'(trig);
            checks++;
            if (trig !== m_trig) begin
                errors++;
                $display("FAIL exact_fit_8 trig: got %0b want %0b", trig, m_trig);
            end
        end
        checks++;
        if (ntrig != 0 || diff !== 10'd8) begin
            errors++;
            $display("FAIL exact_fit_8 hold: got %0d trigs diff=%0d, want 0 trigs diff=8", ntrig, diff);
        end
        committed_prod = 10'd9;
        ntrig = 0;
        repeat (8) begin
            tick();
            ntrig += int'(trig);
            checks++;
            if (trig !== m_trig) begin
                errors++;
                $display("FAIL exact_fit_9 trig: got %0b want %0b", trig, m_trig);
            end
        end
        checks++;
        if (ntrig != 1 || qw_len !== 13'd8 || lst_ben !== 8'hFF || frm_cnt !== 32'd1) begin
            errors++;
            $display("FAIL exact_fit_9 result: got trigs=%0d qw=%0d ben=%h cnt=%0d, want 1/8/ff/1",
                     ntrig, qw_len, lst_ben, frm_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({diff, trig, qw_len, lst_ben, rsk, err, frm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid async: got diff=%0d qw=%0d ben=%h cnt=%0d, want all 0",
                     diff, qw_len, lst_ben, frm_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({diff, trig, qw_len, lst_ben, rsk, err, frm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid held: got diff=%0d qw=%0d ben=%h cnt=%0d, want all 0",
                     diff, qw_len, lst_ben, frm_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (trig !== 1'b0 || frm_cnt !== 32'd0 || diff !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid init: got trig=%0b cnt=%0d diff=%0d, want 0/0/0", trig, frm_cnt, diff);
        end
    endtask

    task automatic test_odd_len();
        int ntrig;
        set_hdr(0, 61);
        set_hdr(9, 60);
        ntrig = 0;
        repeat (10) begin
            tick();
            ntrig += int'(trig);
            checks++;
            if (trig !== m_trig) begin
                errors++;
                $display("FAIL odd_len trig: got %0b want %0b", trig, m_trig);
            end
        end
        checks++;
        if (ntrig != 1 || qw_len !== 13'd8 || lst_ben !== 8'h1F) begin
            errors++;
            $display("FAIL odd_len 61: got trigs=%0d qw=%0d ben=%h, want 1/8/1f", ntrig, qw_len, lst_ben);
        end
        sync = 1'b1;
        rd_ptr = 10'd9;
        committed_prod = 10'd18;
        tick();
        sync = 1'b0;
        ntrig = 0;
        repeat (4) begin
            tick();
            ntrig += int'(trig);
        end
        checks++;
        if (ntrig != 1 || qw_len !== 13'd8 || lst_ben !== 8'h0F || frm_cnt !== 32'd2) begin
            errors++;
            $display("FAIL odd_len 60: got trigs=%0d qw=%0d ben=%h cnt=%0d, want 1/8/0f/2",
                     ntrig, qw_len, lst_ben, frm_cnt);
        end
    endtask

    task automatic test_wrap();
        rd_ptr = 10'h1FC;
        committed_prod = 10'h204;
        tick();
        tick();
        checks++;
        if (diff !== 10'd8 || diff !== 10'(m_diff)) begin
            errors++;
            $display("FAIL wrap diff: got %0d want 8 (model %0d)", diff, m_diff);
        end
        rd_ptr = 10'd0;
        committed_prod = 10'h200;
        tick();
        checks++;
        if (diff !== 10'd512) begin
            errors++;
            $display("FAIL wrap full diff: got %0d want 512", diff);
        end
        tick();
        checks++;
        if (rsk !== 1'b1 || rsk !== m_rsk) begin
            errors++;
            $display("FAIL wrap full rsk: got %0b want 1", rsk);
        end
    endtask

    task automatic test_speculative();
        int ntrig;
        set_hdr(0, 1500);
        rd_ptr = 10'd0;
        committed_prod = 10'd20;
        rsk_tk = 1'b1;
        do_reset();
        ntrig = 0;
        repeat (6) begin
            tick();
            ntrig += int'(trig);
        end
        checks++;
        if (ntrig != 0 || frm_cnt !== 32'd0 || rsk !== 1'b1) begin
            errors++;
            $display("FAIL spec_take: got trigs=%0d cnt=%0d rsk=%0b, want 0/0/1", ntrig, frm_cnt, rsk);
        end
        // A new short header must be ignored until sync: proves the FSM parked in WAIT
        set_hdr(0, 16);
        rsk_tk = 1'b0;
        repeat (4) begin
            tick();
            ntrig += int'(trig);
        end
        checks++;
        if (ntrig != 0) begin
            errors++;
            $display("FAIL spec_wait parked: got %0d trigs want 0", ntrig);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (4) begin
            tick();
            ntrig += int'(trig);
        end
        checks++;
        if (ntrig != 1 || frm_cnt !== 32'd1 || qw_len !== 13'd2) begin
            errors++;
            $display("FAIL spec_after_sync: got trigs=%0d cnt=%0d qw=%0d, want 1/1/2", ntrig, frm_cnt, qw_len);
        end
    endtask

    task automatic test_bad_len();
        int ntrig;
        set_hdr(0, 0);
        rd_ptr = 10'd0;
        committed_prod = 10'd5;
        do_reset();
        repeat (5) tick();
        checks++;
        if (err !== 1'b1 || err !== m_err) begin
            errors++;
            $display("FAIL bad_len zero: got err=%0b want 1", err);
        end
        set_hdr(0, 8);
        ntrig = 0;
        repeat (6) begin
            tick();
            ntrig += int'(trig);
        end
        checks++;
        if (err !== 1'b1 || ntrig != 0) begin
            errors++;
            $display("FAIL bad_len sticky: got err=%0b trigs=%0d, want 1/0", err, ntrig);
        end
        set_hdr(0, 9019);
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_len cleared: got err=%0b want 0", err);
        end
        repeat (5) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_len 9019: got err=%0b want 1", err);
        end
        set_hdr(0, 9018);
        do_reset();
        repeat (6) tick();
        checks++;
        if (err !== 1'b0 || trig !== m_trig) begin
            errors++;
            $display("FAIL bad_len 9018 legal: got err=%0b trig=%0b, want 0/%0b", err, trig, m_trig);
        end
    endtask

    task automatic test_random();
        int occ, l;
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 512; i++) begin
                ring[i] = {$urandom, $urandom};
                if ($urandom_range(199) == 0) l = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(9019, 65535));
                else l = int'($urandom_range(1, 120));
                ring[i][47:32] = 16'(l);
            end
            rd_ptr = 10'(int'($urandom_range(1023)));
            committed_prod = rd_ptr;
            sync = 1'b0;
            rsk_tk = 1'b0;
            do_reset();
            for (int c = 0; c < 250; c++) begin
                occ = (int'(committed_prod) - int'(rd_ptr)) & 1023;
                if ($urandom_range(2) != 0)
                    committed_prod = committed_prod + 10'(int'($urandom_range(0, (512 - occ) < 4 ? 512 - occ : 4)));
                sync = ($urandom_range(5) == 0);
                if (sync) rd_ptr = rd_ptr + 10'(int'($urandom_range(0, occ)));
                rsk_tk = ($urandom_range(7) == 0);
                tick();
                checks++;
                if ({diff, rsk, trig, qw_len, lst_ben, err, frm_cnt} !==
                    {10'(m_diff), m_rsk, m_trig, 13'(m_qw), 8'(m_ben), m_err, m_cnt}) begin
                    errors++;
                    $display("FAIL random blk%0d cyc%0d: got diff=%0d rsk=%0b trig=%0b qw=%0d ben=%h err=%0b cnt=%0d want diff=%0d rsk=%0b trig=%0b qw=%0d ben=%h err=%0b cnt=%0d",
                             blk, c, diff, rsk, trig, qw_len, lst_ben, err, frm_cnt,
                             m_diff, m_rsk, m_trig, m_qw, m_ben[7:0], m_err, m_cnt);
                end
            end
        end
        sync = 1'b0;
        rsk_tk = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        rd_ptr = '0;
        committed_prod = '0;
        rsk_tk = 1'b0;
        sync = 1'b0;
        for (int i = 0; i < 512; i++) ring[i] = '0;
        model_reset();
        test_reset();
        test_exact_fit();
        test_reset_mid();
        test_odd_len();
        test_wrap();
        test_speculative();
        test_bad_len();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
